// File: rtl/bcp_scan_engine.sv
// bcp_scan_engine
//   Boolean constraint propagation over a local clause store. One clause is
//   scanned per cycle. Each unit clause yields an implication, which is offered
//   on a valid/ready handshake and applied to the local assignment as soon as it
//   is accepted. Passes over the store repeat until a pass assigns nothing
//   (fixpoint) or a clause is found falsified (conflict).
// Ports
//   clock, reset                    : rising-edge clock, async active-high reset
//   cl_we/cl_addr/cl_mask/cl_type   : clause store write port (ignored while busy)
//   clause_count, start             : run control, latched when a start is accepted
//   assignment_in, free_in          : initial variable state, latched at start
//   busy                            : high in SCAN and EMIT
//   imp_valid/imp_ready/imp_var/imp_value : implication stream
//   bcp_finish                      : one-cycle end-of-run pulse
//   conflict, conflict_clause       : conflict result, held until the next start
//   assignment_out, free_out        : live local assignment / free vectors
//   pass_count                      : passes taken by the last run
module bcp_scan_engine #(
    parameter  int VAR_NUM    = 8,
    parameter  int CLAUSE_NUM = 16,
    localparam int VW         = $clog2(VAR_NUM),
    localparam int CW         = $clog2(CLAUSE_NUM)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cl_we,
    input  logic [CW-1:0]      cl_addr,
    input  logic [VAR_NUM-1:0] cl_mask,
    input  logic [VAR_NUM-1:0] cl_type,
    input  logic [CW:0]        clause_count,
    input  logic               start,
    input  logic [VAR_NUM-1:0] assignment_in,
    input  logic [VAR_NUM-1:0] free_in,
    output logic               busy,
    output logic               imp_valid,
    input  logic               imp_ready,
    output logic [VW-1:0]      imp_var,
    output logic               imp_value,
    output logic               bcp_finish,
    output logic               conflict,
    output logic [CW-1:0]      conflict_clause,
    output logic [VAR_NUM-1:0] assignment_out,
    output logic [VAR_NUM-1:0] free_out,
    output logic [VW:0]        pass_count
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t state, state_nxt;

    logic [VAR_NUM-1:0] st_mask [CLAUSE_NUM];
    logic [VAR_NUM-1:0] st_type [CLAUSE_NUM];

    logic [VAR_NUM-1:0] a_reg, f_reg;
    logic [CW:0]        cnt;
    logic [CW-1:0]      idx;
    logic               changed;

    // ---------------- clause evaluation on entry idx ----------------
    logic [VAR_NUM-1:0] cur_mask, cur_type, free_m;
    logic               sat, is_conf, is_unit, last, empty_run;
    logic [VW:0]        nfree;
    logic [VW-1:0]      sel;

    assign cur_mask  = st_mask[idx];
    assign cur_type  = st_type[idx];
    assign free_m    = cur_mask & f_reg;
    assign sat       = |(cur_mask & ~f_reg & ~(a_reg ^ cur_type));
    assign is_conf   = !sat && (nfree == '0);
    assign is_unit   = !sat && (nfree == (VW+1)'(1));
    assign empty_run = (cnt == '0);
    // only meaningful when cnt != 0 (empty runs are caught first)
    assign last      = ({1'b0, idx} == cnt - (CW+1)'(1));

    // popcount of free literals; sel ends up on the (single, for a unit) free bit
    always_comb begin
        nfree = '0;
        sel   = '0;
        for (int i = 0; i < VAR_NUM; i++) begin
            if (free_m[i]) begin
                nfree = nfree + (VW+1)'(1);
                sel   = VW'(i);
            end
        end
    end

    // ---------------- clause store ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CLAUSE_NUM; i++) begin
                st_mask[i] <= '0;
                st_type[i] <= '0;
            end
        end else if (cl_we && !busy) begin
            st_mask[cl_addr] <= cl_mask;
            st_type[cl_addr] <= cl_type;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SCAN;
            SCAN: begin
                if (empty_run || is_conf)  state_nxt = DONE;
                else if (is_unit)          state_nxt = EMIT;
                else if (last && !changed) state_nxt = DONE;
            end
            // an accepted implication always marks the pass as changed, so
            // even at the last clause we go back to SCAN for another pass
            EMIT: if (imp_ready) state_nxt = SCAN;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = (state == SCAN) || (state == EMIT);
        bcp_finish = (state == DONE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg           <= '0;
            f_reg           <= '0;
            cnt             <= '0;
            idx             <= '0;
            changed         <= 1'b0;
            pass_count      <= '0;
            imp_valid       <= 1'b0;
            imp_var         <= '0;
            imp_value       <= 1'b0;
            conflict        <= 1'b0;
            conflict_clause <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_reg           <= assignment_in;
                    f_reg           <= free_in;
                    cnt             <= clause_count;
                    idx             <= '0;
                    changed         <= 1'b0;
                    pass_count      <= (VW+1)'(1);
                    conflict        <= 1'b0;
                    conflict_clause <= '0;
                end
                SCAN: if (!empty_run) begin
                    if (is_conf) begin
                        conflict        <= 1'b1;
                        conflict_clause <= idx;
                    end else if (is_unit) begin
                        imp_valid <= 1'b1;
                        imp_var   <= sel;
                        imp_value <= cur_type[sel];
                    end else if (last) begin
                        if (changed) begin
                            idx        <= '0;
                            changed    <= 1'b0;
                            pass_count <= pass_count + (VW+1)'(1);
                        end
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                EMIT: if (imp_ready) begin
                    a_reg[imp_var] <= imp_value;
                    f_reg[imp_var] <= 1'b0;
                    imp_valid      <= 1'b0;
                    if (last) begin
                        idx        <= '0;
                        changed    <= 1'b0;
                        pass_count <= pass_count + (VW+1)'(1);
                    end else begin
                        idx     <= idx + CW'(1);
                        changed <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign assignment_out = a_reg;
    assign free_out       = f_reg;

endmodule

// File: tb/tb_bcp_scan_engine.sv
module tb_bcp_scan_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cl_we = 1'b0;
    logic [3:0] cl_addr = '0;
    logic [7:0] cl_mask = '0, cl_type = '0;
    logic [4:0] clause_count = '0;
    logic       start = 1'b0;
    logic [7:0] assignment_in = '0, free_in = '0;
    logic       imp_ready = 1'b1;
    logic       busy, imp_valid, imp_value, bcp_finish, conflict;
    logic [2:0] imp_var;
    logic [3:0] conflict_clause, pass_count;
    logic [7:0] assignment_out, free_out;

    int errs = 0;
    int checks = 0;
    logic [3:0] exp_q[$];   // {var, value} of expected implications, in order

    bcp_scan_engine #(.VAR_NUM(8), .CLAUSE_NUM(16)) dut (
        .clock(clock), .reset(reset), .cl_we(cl_we), .cl_addr(cl_addr),
        .cl_mask(cl_mask), .cl_type(cl_type), .clause_count(clause_count),
        .start(start), .assignment_in(assignment_in), .free_in(free_in),
        .busy(busy), .imp_valid(imp_valid), .imp_ready(imp_ready),
        .imp_var(imp_var), .imp_value(imp_value), .bcp_finish(bcp_finish),
        .conflict(conflict), .conflict_clause(conflict_clause),
        .assignment_out(assignment_out), .free_out(free_out),
        .pass_count(pass_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // scoreboard: every accepted implication must match the queue head
    always @(negedge clock) begin
        if (!reset && imp_valid && imp_ready) begin
            if (exp_q.size() == 0) chk("imp_extra", {imp_var, imp_value}, 32'hFFFF);
            else chk("imp", {imp_var, imp_value}, exp_q.pop_front());
        end
    end

    task automatic load(input logic [3:0] a, input logic [7:0] m, input logic [7:0] t);
        @(posedge clock); #1;
        cl_we = 1'b1; cl_addr = a; cl_mask = m; cl_type = t;
        @(posedge clock); #1;
        cl_we = 1'b0;
    endtask

    // returns just after the edge that accepts the start
    task automatic start_run(input logic [4:0] n, input logic [7:0] a, input logic [7:0] f);
        @(posedge clock); #1;
        clause_count = n; assignment_in = a; free_in = f; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int c = 0;
        while (!imp_valid && c < 50) begin @(posedge clock); #1; c++; end
        chk({tag, "_valid"}, imp_valid, 1);
    endtask

    // exp_cyc: cycles from the accepting edge to bcp_finish, 0 = not checked
    task automatic wait_finish(input string tag, input int exp_cyc, input logic exp_conf,
                               input logic [3:0] exp_cc, input logic [7:0] exp_a,
                               input logic [7:0] exp_f, input logic [3:0] exp_pc);
        int c = 1;
        while (!bcp_finish && c < 300) begin @(posedge clock); #1; c++; end
        chk({tag, "_fin"}, bcp_finish, 1);
        if (exp_cyc > 0) chk({tag, "_cyc"}, c, exp_cyc);
        chk({tag, "_conf"}, conflict, exp_conf);
        if (exp_conf) chk({tag, "_cc"}, conflict_clause, exp_cc);
        chk({tag, "_a"}, assignment_out, exp_a);
        chk({tag, "_f"}, free_out, exp_f);
        chk({tag, "_pc"}, pass_count, exp_pc);
        chk({tag, "_qleft"}, exp_q.size(), 0);
        @(posedge clock); #1;
        chk({tag, "_pulse"}, bcp_finish, 0);
        chk({tag, "_busy"}, busy, 0);
        @(posedge clock); #1;
        chk({tag, "_hold"}, conflict, exp_conf);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_z"}, {busy, imp_valid, imp_var, imp_value, bcp_finish, conflict,
                          conflict_clause, assignment_out, free_out, pass_count}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_zero("rst");
        @(posedge clock); #1; reset = 1'b0;
        chk_zero("rst_rel");

        // 1: single unit clause
        load(0, 8'h03, 8'h01);
        exp_q.push_back({3'd0, 1'b1});
        start_run(1, 8'h02, 8'h01);
        wait_finish("s1", 4, 0, 0, 8'h03, 8'h00, 2);

        // 2: chain resolved within one pass
        load(0, 8'h03, 8'h02);
        load(1, 8'h06, 8'h04);
        exp_q.push_back({3'd1, 1'b1});
        exp_q.push_back({3'd2, 1'b1});
        start_run(2, 8'h01, 8'hFE);
        wait_finish("s2", 7, 0, 0, 8'h07, 8'hF8, 2);

        // reversed chain needs a third pass
        load(0, 8'h06, 8'h04);
        load(1, 8'h03, 8'h02);
        exp_q.push_back({3'd1, 1'b1});
        exp_q.push_back({3'd2, 1'b1});
        start_run(2, 8'h01, 8'hFE);
        wait_finish("s2r", 0, 0, 0, 8'h07, 8'hF8, 3);

        // 3: immediate conflict
        load(0, 8'h03, 8'h03);
        start_run(1, 8'h00, 8'h00);
        wait_finish("s3", 2, 1, 0, 8'h00, 8'h00, 1);

        // three satisfied clauses: finish N+1 cycles after start
        load(0, 8'h01, 8'h01);
        load(1, 8'h02, 8'h02);
        load(2, 8'h04, 8'h04);
        start_run(3, 8'h07, 8'h00);
        wait_finish("sat3", 4, 0, 0, 8'h07, 8'h00, 1);

        // conflict on the last clause of three
        load(2, 8'h04, 8'h00);
        start_run(3, 8'h07, 8'h00);
        wait_finish("conf2", 4, 1, 2, 8'h07, 8'h00, 1);

        // 4: backpressure
        load(0, 8'h03, 8'h01);
        imp_ready = 1'b0;
        exp_q.push_back({3'd0, 1'b1});
        start_run(1, 8'h02, 8'h01);
        wait_valid("s4");
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("s4_stable", {imp_valid, imp_var, imp_value}, {1'b1, 3'd0, 1'b1});
        end
        imp_ready = 1'b1;
        wait_finish("s4", 0, 0, 0, 8'h03, 8'h00, 2);

        // 5: empty run, empty clause
        start_run(0, 8'h5A, 8'h81);
        wait_finish("s5_cnt0", 2, 0, 0, 8'h5A, 8'h81, 1);
        load(3, 8'h00, 8'h00);
        load(0, 8'h00, 8'h00);
        start_run(1, 8'h00, 8'hFF);
        wait_finish("s5_empty", 2, 1, 0, 8'h00, 8'hFF, 1);

        // 5: start and cl_we while busy are ignored
        load(0, 8'h03, 8'h01);
        imp_ready = 1'b0;
        exp_q.push_back({3'd0, 1'b1});
        start_run(1, 8'h02, 8'h01);
        wait_valid("s5_busy");
        start = 1'b1; assignment_in = 8'h00; free_in = 8'hFF; clause_count = 0;
        cl_we = 1'b1; cl_addr = 0; cl_mask = 8'h00; cl_type = 8'h00;
        @(posedge clock); #1;
        @(posedge clock); #1;
        start = 1'b0; cl_we = 1'b0;
        imp_ready = 1'b1;
        wait_finish("s5_busy", 0, 0, 0, 8'h03, 8'h00, 2);
        exp_q.push_back({3'd0, 1'b1});
        start_run(1, 8'h02, 8'h01);
        wait_finish("s5_store", 4, 0, 0, 8'h03, 8'h00, 2);

        // 6: reset during EMIT
        imp_ready = 1'b0;
        exp_q.push_back({3'd0, 1'b1});
        start_run(1, 8'h02, 8'h01);
        wait_valid("s6");
        #2 reset = 1'b1;
        #1 chk_zero("s6_async");
        @(posedge clock); #1;
        chk_zero("s6_held");
        reset = 1'b0;
        exp_q.delete();
        imp_ready = 1'b1;
        @(posedge clock); #1;
        chk("s6_nofin", {busy, bcp_finish}, 0);
        // store cleared: clause 0 is now empty, so this must conflict
        start_run(1, 8'h00, 8'h00);
        wait_finish("s6_clr", 2, 1, 0, 8'h00, 8'h00, 1);
        load(0, 8'h03, 8'h01);
        exp_q.push_back({3'd0, 1'b1});
        start_run(1, 8'h02, 8'h01);
        wait_finish("s6_rerun", 4, 0, 0, 8'h03, 8'h00, 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
